// File: rtl/pu_msp430_dbg_uart_host.sv
// Host-side master for the debug UART link: sends a sync character, then turns single
// register requests into command/data frames and collects read data from the target.
module pu_msp430_dbg_uart_host #(
    parameter int CLK_PER_BIT  = 16,
    parameter int GAP_BITS     = 2,
    parameter int TIMEOUT_BITS = 64
) (
    input  logic        dbg_clk,
    input  logic        dbg_rst,
    output logic        dbg_uart_txd,
    input  logic        dbg_uart_rxd,
    output logic        sync_done,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_wr,
    input  logic        req_bw,
    input  logic [5:0]  req_addr,
    input  logic [15:0] req_wdata,
    output logic        rsp_valid,
    output logic [15:0] rsp_rdata,
    output logic        rsp_err
);

    localparam int CW          = $clog2(CLK_PER_BIT);
    localparam int FRAME_BITS  = 10;
    localparam int SEQ_BITS    = FRAME_BITS + GAP_BITS;
    localparam int IW          = $clog2(SEQ_BITS + 1);
    localparam int TW          = (TIMEOUT_BITS > 1) ? $clog2(TIMEOUT_BITS) : 1;
    localparam int SYNC_STAGES = 2;

    localparam logic [CW-1:0] CYC_LAST     = CW'(CLK_PER_BIT - 1);
    localparam logic [CW-1:0] CYC_HALF     = CW'(CLK_PER_BIT / 2 - 1);
    localparam logic [IW-1:0] IDX_STOP     = IW'(FRAME_BITS - 1);
    localparam logic [IW-1:0] IDX_LAST     = IW'(SEQ_BITS - 1);
    localparam logic [IW-1:0] IDX_PRE_LAST = IW'(GAP_BITS - 1);
    localparam logic [TW-1:0] TO_LAST      = TW'(TIMEOUT_BITS - 1);
    localparam logic [7:0]    SYNC_CHAR    = 8'h80;

    typedef enum logic [2:0] {
        ST_SYNC,
        ST_IDLE,
        ST_TX_CMD,
        ST_TX_D0,
        ST_TX_D1,
        ST_RX_D0,
        ST_RX_D1
    } state_t;

    state_t            state_reg;
    logic              sync_done_reg;
    logic              sync_frame_reg;
    logic [CW-1:0]     cyc_reg;
    logic [IW-1:0]     idx_reg;
    logic [8:0]        tx_shift_reg;
    logic              txd_reg;
    logic              wr_reg;
    logic              bw_reg;
    logic [15:0]       wdata_reg;

    logic [SYNC_STAGES-1:0] rx_sync_reg;
    logic              rx_prev_reg;
    logic              rx_busy_reg;
    logic [CW-1:0]     rx_cyc_reg;
    logic [3:0]        rx_bit_reg;
    logic [7:0]        rx_shift_reg;
    logic [7:0]        rx_b0_reg;
    logic              rx_ferr_reg;
    logic [TW-1:0]     to_reg;

    logic              rsp_valid_reg;
    logic [15:0]       rsp_rdata_reg;
    logic              rsp_err_reg;

    logic              rx_s;
    logic              tx_state;
    logic              bit_end;
    logic              seq_end;
    logic              stop_end;
    logic              to_phase;

    assign rx_s     = rx_sync_reg[SYNC_STAGES-1];
    assign tx_state = (state_reg == ST_SYNC) || (state_reg == ST_TX_CMD) ||
                      (state_reg == ST_TX_D0) || (state_reg == ST_TX_D1);
    assign bit_end  = (cyc_reg == CYC_LAST);
    assign seq_end  = bit_end && (idx_reg == IDX_LAST);
    assign stop_end = bit_end && (idx_reg == IDX_STOP);
    // The timeout runs while hunting and while a candidate start bit is re-checked.
    assign to_phase = !rx_busy_reg || (rx_bit_reg == 4'd0);

    assign dbg_uart_txd = txd_reg;
    assign sync_done    = sync_done_reg;
    assign req_ready    = sync_done_reg && (state_reg == ST_IDLE);
    assign rsp_valid    = rsp_valid_reg;
    assign rsp_rdata    = rsp_rdata_reg;
    assign rsp_err      = rsp_err_reg;

    always_ff @(posedge dbg_clk or posedge dbg_rst) begin
        if (dbg_rst) begin
            rx_sync_reg <= '1;
            rx_prev_reg <= 1'b1;
        end else begin
            rx_sync_reg <= {rx_sync_reg[SYNC_STAGES-2:0], dbg_uart_rxd};
            rx_prev_reg <= rx_s;
        end
    end

    always_ff @(posedge dbg_clk or posedge dbg_rst) begin
        if (dbg_rst) begin
            state_reg      <= ST_SYNC;
            sync_done_reg  <= 1'b0;
            sync_frame_reg <= 1'b0;
            cyc_reg        <= '0;
            idx_reg        <= '0;
            tx_shift_reg   <= '1;
            txd_reg        <= 1'b1;
            wr_reg         <= 1'b0;
            bw_reg         <= 1'b0;
            wdata_reg      <= '0;
            rx_busy_reg    <= 1'b0;
            rx_cyc_reg     <= '0;
            rx_bit_reg     <= '0;
            rx_shift_reg   <= '0;
            rx_b0_reg      <= '0;
            rx_ferr_reg    <= 1'b0;
            to_reg         <= '0;
            rsp_valid_reg  <= 1'b0;
            rsp_rdata_reg  <= '0;
            rsp_err_reg    <= 1'b0;
        end else begin
            rsp_valid_reg <= 1'b0;

            // Shared bit timing: the shifter back-fills ones so stop and gap bits stay high.
            if (tx_state) begin
                if (bit_end) begin
                    cyc_reg      <= '0;
                    idx_reg      <= idx_reg + IW'(1);
                    txd_reg      <= tx_shift_reg[0];
                    tx_shift_reg <= {1'b1, tx_shift_reg[8:1]};
                end else begin
                    cyc_reg <= cyc_reg + CW'(1);
                end
            end

            case (state_reg)
                ST_SYNC: begin
                    if (!sync_frame_reg && bit_end && (idx_reg == IDX_PRE_LAST)) begin
                        sync_frame_reg <= 1'b1;
                        txd_reg        <= 1'b0;
                        tx_shift_reg   <= {1'b1, SYNC_CHAR};
                        cyc_reg        <= '0;
                        idx_reg        <= '0;
                    end else if (sync_frame_reg && seq_end) begin
                        sync_done_reg <= 1'b1;
                        state_reg     <= ST_IDLE;
                    end
                end

                ST_IDLE: begin
                    if (req_valid && req_ready) begin
                        wr_reg       <= req_wr;
                        bw_reg       <= req_bw;
                        wdata_reg    <= req_wdata;
                        txd_reg      <= 1'b0;
                        tx_shift_reg <= {1'b1, req_wr, req_bw, req_addr};
                        cyc_reg      <= '0;
                        idx_reg      <= '0;
                        state_reg    <= ST_TX_CMD;
                    end
                end

                ST_TX_CMD: begin
                    if (!wr_reg && stop_end) begin
                        cyc_reg     <= '0;
                        to_reg      <= '0;
                        rx_busy_reg <= 1'b0;
                        rx_ferr_reg <= 1'b0;
                        state_reg   <= ST_RX_D0;
                    end else if (wr_reg && seq_end) begin
                        txd_reg      <= 1'b0;
                        tx_shift_reg <= {1'b1, wdata_reg[7:0]};
                        cyc_reg      <= '0;
                        idx_reg      <= '0;
                        state_reg    <= ST_TX_D0;
                    end
                end

                ST_TX_D0: begin
                    if (seq_end) begin
                        if (bw_reg) begin
                            rsp_valid_reg <= 1'b1;
                            rsp_err_reg   <= 1'b0;
                            state_reg     <= ST_IDLE;
                        end else begin
                            txd_reg      <= 1'b0;
                            tx_shift_reg <= {1'b1, wdata_reg[15:8]};
                            cyc_reg      <= '0;
                            idx_reg      <= '0;
                            state_reg    <= ST_TX_D1;
                        end
                    end
                end

                ST_TX_D1: begin
                    if (seq_end) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end
                end

                ST_RX_D0, ST_RX_D1: begin
                    if (to_phase) begin
                        if (bit_end) begin
                            cyc_reg <= '0;
                            to_reg  <= to_reg + TW'(1);
                        end else begin
                            cyc_reg <= cyc_reg + CW'(1);
                        end
                    end

                    if (to_phase && bit_end && (to_reg == TO_LAST)) begin
                        rsp_valid_reg <= 1'b1;
                        rsp_err_reg   <= 1'b1;
                        rsp_rdata_reg <= '0;
                        rx_busy_reg   <= 1'b0;
                        state_reg     <= ST_IDLE;
                    end else if (!rx_busy_reg) begin
                        if (rx_prev_reg && !rx_s) begin
                            rx_busy_reg <= 1'b1;
                            rx_cyc_reg  <= '0;
                            rx_bit_reg  <= '0;
                        end
                    end else if (rx_bit_reg == 4'd0) begin
                        // Half-bit re-check filters glitches shorter than half a bit.
                        if (rx_cyc_reg == CYC_HALF) begin
                            if (rx_s) begin
                                rx_busy_reg <= 1'b0;
                            end else begin
                                rx_bit_reg <= 4'd1;
                                rx_cyc_reg <= '0;
                            end
                        end else begin
                            rx_cyc_reg <= rx_cyc_reg + CW'(1);
                        end
                    end else if (rx_cyc_reg == CYC_LAST) begin
                        rx_cyc_reg <= '0;
                        if (rx_bit_reg == 4'd9) begin
                            rx_busy_reg <= 1'b0;
                            cyc_reg     <= '0;
                            to_reg      <= '0;
                            if ((state_reg == ST_RX_D0) && !bw_reg) begin
                                rx_b0_reg   <= rx_shift_reg;
                                rx_ferr_reg <= rx_ferr_reg | ~rx_s;
                                state_reg   <= ST_RX_D1;
                            end else begin
                                rsp_valid_reg <= 1'b1;
                                rsp_err_reg   <= rx_ferr_reg | ~rx_s;
                                rsp_rdata_reg <= bw_reg ? {8'h00, rx_shift_reg}
                                                        : {rx_shift_reg, rx_b0_reg};
                                state_reg     <= ST_IDLE;
                            end
                        end else begin
                            rx_shift_reg <= {rx_s, rx_shift_reg[7:1]};
                            rx_bit_reg   <= rx_bit_reg + 4'd1;
                        end
                    end else begin
                        rx_cyc_reg <= rx_cyc_reg + CW'(1);
                    end
                end

                default: state_reg <= ST_IDLE;
            endcase
        end
    end

endmodule
